// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic units.
package serial_arith_pkg;

   localparam int DEFAULT_WIDTH = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

   function automatic logic majority3(input logic x, input logic y, input logic z);
      return (x & y) | (x & z) | (y & z);
   endfunction

endpackage

// File: rtl/full_adder_cell.sv
// 1-bit arithmetic cells. With SERIAL_ADDER_SUB_EN an add/subtract cell is also provided,
// its borrow path using the full-subtractor equations.
module full_adder_cell
   import serial_arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ c;
   assign co = majority3(a, b, c);

endmodule

`ifdef SERIAL_ADDER_SUB_EN
module addsub_cell
   import serial_arith_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic c,
   input  logic sub,
   output logic s,
   output logic co
);

   logic borrow_s;

   assign borrow_s = (~a & b) | (~a & c) | (b & c);
   assign s        = a ^ b ^ c;
   assign co       = sub ? borrow_s : majority3(a, b, c);

endmodule
`endif

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, LSB first, result published on the DONE cycle.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b - cin with borrow-out on cout).
module serial_adder
   import serial_arith_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [WIDTH-1:0] a_sr_r;
   logic [WIDTH-1:0] b_sr_r;
   logic [WIDTH-1:0] sum_sr_r;
   logic             carry_r;
   logic [CNT_W-1:0] count_r;
   logic             bit_s;
   logic             carry_nxt_s;

`ifdef SERIAL_ADDER_SUB_EN
   logic sub_r;

   addsub_cell u_cell (
      .a   (a_sr_r[0]),
      .b   (b_sr_r[0]),
      .c   (carry_r),
      .sub (sub_r),
      .s   (bit_s),
      .co  (carry_nxt_s)
   );

   // Mode flag is captured together with the operands.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_r <= 1'b0;
      end else if (state_r == IDLE && start) begin
         sub_r <= sub;
      end
   end
`else
   full_adder_cell u_cell (
      .a  (a_sr_r[0]),
      .b  (b_sr_r[0]),
      .c  (carry_r),
      .s  (bit_s),
      .co (carry_nxt_s)
   );
`endif

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_nxt_s = SHIFT;
            else       state_nxt_s = IDLE;
         end
         SHIFT: begin
            if (count_r == LAST_CNT) state_nxt_s = DONE;
            else                     state_nxt_s = SHIFT;
         end
         DONE:    state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // State, datapath and registered outputs; sum/cout only move on the DONE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         sum      <= {WIDTH{1'b0}};
         cout     <= 1'b0;
         a_sr_r   <= {WIDTH{1'b0}};
         b_sr_r   <= {WIDTH{1'b0}};
         sum_sr_r <= {WIDTH{1'b0}};
         carry_r  <= 1'b0;
         count_r  <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         busy    <= (state_nxt_s == SHIFT);
         done    <= (state_r == DONE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_sr_r  <= a;
                  b_sr_r  <= b;
                  carry_r <= cin;
                  count_r <= {CNT_W{1'b0}};
               end
            end
            SHIFT: begin
               carry_r  <= carry_nxt_s;
               a_sr_r   <= a_sr_r >> 1;
               b_sr_r   <= b_sr_r >> 1;
               sum_sr_r <= {bit_s, sum_sr_r[WIDTH-1:1]};
               count_r  <= count_r + CNT_W'(1);
            end
            DONE: begin
               sum  <= sum_sr_r;
               cout <= carry_r;
            end
            default: begin
               count_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = 8'h00;
   logic [W-1:0] b = 8'h00;
   logic         cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub = 1'b0;
`endif
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks = 0;
   int errors = 0;

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: {cout,sum} = a + b + cin, or a - b - cin with borrow-out in subtract mode.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
      if (s) return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
      else   return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
   endfunction

   task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                           input logic s);
      @(negedge clk);
      a = x; b = y; cin = c; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
      sub = s;
`endif
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
   endtask

   // Counts negedges after the accepting edge until done; optionally pokes start mid-flight.
   task automatic wait_done(input int inject_at, output int cycles, output int busy_cnt,
                            output bit sum_moved);
      logic [W-1:0] entry_sum;
      entry_sum = sum;
      cycles = -1;
      busy_cnt = busy ? 1 : 0;
      sum_moved = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         if (i == inject_at) begin
            a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         if (done) begin
            cycles = i;
            break;
         end
         if (busy) busy_cnt++;
         if (sum !== entry_sum) sum_moved = 1'b1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                  busy, done, sum, cout);
      end
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0] va [3] = '{8'h5A, 8'hFF, 8'hFF};
      logic [W-1:0] vb [3] = '{8'h3C, 8'h01, 8'hFF};
      logic         vc [3] = '{1'b0, 1'b0, 1'b1};
      int cyc, bc;
      bit moved;
      for (int k = 0; k < 3; k++) begin
         start_op(va[k], vb[k], vc[k], 1'b0);
         wait_done(0, cyc, bc, moved);
         checks++;
         if (cyc !== W + 1 || bc !== W) begin
            errors++;
            $display("FAIL directed_timing[%0d]: done_after=%0d busy=%0d, want %0d %0d",
                     k, cyc, bc, W + 1, W);
         end
         checks++;
         if ({cout, sum} !== model(va[k], vb[k], vc[k], 1'b0)) begin
            errors++;
            $display("FAIL directed_result[%0d]: got %b_%h, want %h", k, cout, sum,
                     model(va[k], vb[k], vc[k], 1'b0));
         end
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width[%0d]: done=%b, want 0", k, done);
         end
      end
   endtask

   task automatic test_random();
      int cyc, bc;
      bit moved;
      logic [W-1:0] x, y;
      logic c, s;
      for (int k = 0; k < 40; k++) begin
         x = W'($urandom); y = W'($urandom); c = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         start_op(x, y, c, s);
         wait_done(0, cyc, bc, moved);
         checks++;
         if (cyc !== W + 1 || {cout, sum} !== model(x, y, c, s)) begin
            errors++;
            $display("FAIL random[%0d]: a=%h b=%h c=%b s=%b got %b_%h after %0d, want %h after %0d",
                     k, x, y, c, s, cout, sum, cyc, model(x, y, c, s), W + 1);
         end
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bc, extra;
      bit moved;
      start_op(8'h10, 8'h20, 1'b0, 1'b0);
      wait_done(2, cyc, bc, moved);
      checks++;
      if (cyc !== W + 1 || sum !== 8'h30 || cout !== 1'b0) begin
         errors++;
         $display("FAIL start_while_busy: sum=%h cout=%b after %0d, want 30 0 after %0d",
                  sum, cout, cyc, W + 1);
      end
      extra = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL ignored_start_activity: cycles with busy/done=%0d, want 0", extra);
      end
      start_op(8'h0F, 8'h01, 1'b0, 1'b0);
      wait_done(0, cyc, bc, moved);
      checks++;
      if (moved !== 1'b0) begin
         errors++;
         $display("FAIL result_hold: sum moved before done=%b, want 0", moved);
      end
      checks++;
      if (sum !== 8'h10 || cout !== 1'b0) begin
         errors++;
         $display("FAIL result_update: sum=%h cout=%b, want 10 0", sum, cout);
      end
   endtask

   task automatic test_reset_mid_op();
      int cyc, bc, extra;
      bit moved;
      start_op(8'hAA, 8'h55, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk); @(negedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, sum, cout} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL async_reset: busy=%b done=%b sum=%h cout=%b, want 0 0 00 0",
                  busy, done, sum, cout);
      end
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done || busy) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL aborted_op_done: cycles with busy/done=%0d, want 0", extra);
      end
      start_op(8'hAA, 8'h55, 1'b0, 1'b0);
      wait_done(0, cyc, bc, moved);
      checks++;
      if (cyc !== W + 1 || sum !== 8'hFF || cout !== 1'b0) begin
         errors++;
         $display("FAIL restart_after_reset: sum=%h cout=%b after %0d, want ff 0 after %0d",
                  sum, cout, cyc, W + 1);
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      int cyc, bc;
      bit moved;
      start_op(8'h10, 8'h01, 1'b0, 1'b1);
      wait_done(0, cyc, bc, moved);
      checks++;
      if (sum !== 8'h0F || cout !== 1'b0) begin
         errors++;
         $display("FAIL sub_basic: sum=%h cout=%b, want 0f 0", sum, cout);
      end
      start_op(8'h00, 8'h01, 1'b0, 1'b1);
      wait_done(0, cyc, bc, moved);
      checks++;
      if (sum !== 8'hFF || cout !== 1'b1) begin
         errors++;
         $display("FAIL sub_borrow: sum=%h cout=%b, want ff 1", sum, cout);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid_op();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
